// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multiplexed hex display.
package hex_disp_pkg;

   // Display modes, encoded as presented on iMODE
   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_SCROLL = 2'b10,
      MODE_OFF    = 2'b11
   } mode_e;

   // All segments unlit, expressed in active-high sense (bit 0 = a .. bit 6 = g)
   localparam logic [6:0] SEG_BLANK_HI = 7'h00;

   // Active-high glyphs; entry n is the pattern for hex digit n (0-9, A, b, C, d, E, F)
   localparam logic [15:0][6:0] GLYPH_HI = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Blank-digit pattern in the polarity actually driven onto the pins
   function automatic logic [6:0] seg_blank(input bit active_low);
      return active_low ? ~SEG_BLANK_HI : SEG_BLANK_HI;
   endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// One digit: 4-bit value to 7-segment pattern, with blanking and output polarity.
module hex_seg_decode
   import hex_disp_pkg::*;
#(
   parameter int ACTIVE_LOW = 1
) (
   input  logic [3:0] i_nib,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   logic [6:0] w_hi;

   // Look up the glyph, override with blank, then apply pin polarity
   always_comb begin
      w_hi = GLYPH_HI[i_nib];
      if (i_blank) w_hi = SEG_BLANK_HI;
      o_seg = (ACTIVE_LOW != 0) ? ~w_hi : w_hi;
   end

endmodule

// File: rtl/hex_multi_display.sv
// Multi-digit hex display with static, blink, scroll and off modes.
// Display path is one register deep: state captured on edge N shows on edge N+1.
module hex_multi_display
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int TICK_DIV   = 25_000_000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    iCLK,
   input  logic                    iRST,
   input  logic [4*NUM_DIGITS-1:0] iDATA,
   input  logic                    iLOAD,
   output logic                    oREADY,
   input  logic [1:0]              iMODE,
   input  logic                    iLZB,
   output logic [7*NUM_DIGITS-1:0] oHEX
);

   localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int         OW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0] BLANK_SEG = seg_blank(ACTIVE_LOW != 0);

   logic [4*NUM_DIGITS-1:0]     r_data;
   logic [PW-1:0]               r_presc;
   logic [OW-1:0]               r_off;
   logic                        r_phase;
   mode_e                       r_mode;
   logic [NUM_DIGITS-1:0][6:0]  r_hex;

   logic                        w_tick;
   logic                        w_mode_chg;
   logic                        w_load;
   logic                        w_any;
   int                          w_idx;
   logic [NUM_DIGITS-1:0]       w_keep;
   logic [NUM_DIGITS-1:0][3:0]  w_nib;
   logic [NUM_DIGITS-1:0]       w_blank;
   logic [NUM_DIGITS-1:0][6:0]  w_seg;

   assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
   assign w_mode_chg = (mode_e'(iMODE) != r_mode);
   // A scroll pass must finish (offset back at 0) before new data is taken
   assign oREADY     = (r_mode != MODE_SCROLL) || (r_off == '0);
   assign w_load     = iLOAD && oREADY;
   assign oHEX       = r_hex;

   // Leading-zero mask: digit k is kept if any nibble at or above k is non-zero; digit 0 always kept
   always_comb begin
      w_any  = 1'b0;
      w_keep = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_any     = w_any | (|r_data[4*i +: 4]);
         w_keep[i] = w_any || (i == 0);
      end
   end

   // Per-digit nibble selection (rotated in scroll) and blanking by mode
   always_comb begin
      w_nib   = '0;
      w_blank = '0;
      w_idx   = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_idx = i;
         if (r_mode == MODE_SCROLL) begin
            w_idx = i + int'(r_off);
            if (w_idx >= NUM_DIGITS) w_idx = w_idx - NUM_DIGITS;
         end
         w_nib[i] = r_data[4*w_idx +: 4];
         case (r_mode)
            MODE_STATIC: w_blank[i] = iLZB && !w_keep[i];
            MODE_BLINK:  w_blank[i] = r_phase;
            MODE_SCROLL: w_blank[i] = 1'b0;
            default:     w_blank[i] = 1'b1;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      hex_seg_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
         .i_nib   (w_nib[g]),
         .i_blank (w_blank[g]),
         .o_seg   (w_seg[g])
      );
   end

   // Data, prescaler, scroll offset, blink phase, mode history and registered segments
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_data  <= '0;
         r_presc <= '0;
         r_off   <= '0;
         r_phase <= 1'b0;
         r_mode  <= MODE_STATIC;
         r_hex   <= {NUM_DIGITS{BLANK_SEG}};
      end else begin
         r_hex <= w_seg;
         if (w_load) r_data <= iDATA;
         if (w_mode_chg) begin
            // mode change restarts every animation from a known point
            r_presc <= '0;
            r_off   <= '0;
            r_phase <= 1'b0;
            r_mode  <= mode_e'(iMODE);
         end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
               r_phase <= ~r_phase;
               if (r_mode == MODE_SCROLL)
                  r_off <= (r_off == OW'(NUM_DIGITS - 1)) ? '0 : r_off + OW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_multi_display.sv
// Directed bench for hex_multi_display (4 digits, tick every 4 cycles, active-low).
module tb_hex_multi_display;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [15:0] iDATA;
   logic        iLOAD;
   logic        oREADY;
   logic [1:0]  iMODE;
   logic        iLZB;
   logic [27:0] oHEX;

   int errs = 0;
   int nchk = 0;

   localparam logic [27:0] ALL_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
   localparam logic [27:0] SHOW_0123 = {7'h40, 7'h79, 7'h24, 7'h30};

   hex_multi_display #(.NUM_DIGITS(4), .TICK_DIV(4), .ACTIVE_LOW(1)) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iDATA  (iDATA),
      .iLOAD  (iLOAD),
      .oREADY (oREADY),
      .iMODE  (iMODE),
      .iLZB   (iLZB),
      .oHEX   (oHEX)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // advance n rising edges, leave time 1 unit past the last one
   task automatic step(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   initial begin
      iRST = 1'b1; iDATA = '0; iLOAD = 1'b0; iMODE = 2'b00; iLZB = 1'b0;
      step(2);
      chk("rst_hex", 32'(oHEX), 32'(ALL_BLANK));
      chk("rst_rdy", 32'(oREADY), 32'd1);
      iRST = 1'b0;

      // static, leading-zero blanking
      iDATA = 16'h0012; iLOAD = 1'b1; iLZB = 1'b1;
      step(1);
      iLOAD = 1'b0;
      chk("lzb_lat", 32'(oHEX), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
      step(1);
      chk("lzb_on", 32'(oHEX), 32'({7'h7F, 7'h7F, 7'h79, 7'h24}));
      iLZB = 1'b0;
      step(1);
      chk("lzb_off", 32'(oHEX), 32'({7'h40, 7'h40, 7'h79, 7'h24}));

      // blink, entered together with a load
      iMODE = 2'b01; iDATA = 16'h0123; iLOAD = 1'b1;
      step(1);
      iLOAD = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         chk($sformatf("blink%0d", k), 32'(oHEX),
             (((k - 1) / 4) % 2 == 0) ? 32'(SHOW_0123) : 32'(ALL_BLANK));
      end

      // scroll; load held pending until offset wraps
      iMODE = 2'b10;
      step(1);
      step(1);
      chk("scr_off0", 32'(oHEX), 32'(SHOW_0123));
      step(3);
      chk("scr_rdy0", 32'(oREADY), 32'd0);
      step(1);
      chk("scr_off1", 32'(oHEX), 32'({7'h30, 7'h40, 7'h79, 7'h24}));
      chk("scr_dig0", 32'(oHEX[6:0]), 32'h24);
      iDATA = 16'hAAAA; iLOAD = 1'b1;
      step(10);
      chk("scr_rdy15", 32'(oREADY), 32'd0);
      step(1);
      chk("scr_rdy16", 32'(oREADY), 32'd1);
      chk("scr_off3", 32'(oHEX), 32'({7'h79, 7'h24, 7'h30, 7'h40}));
      step(1);
      iLOAD = 1'b0;
      chk("scr_wrap", 32'(oHEX), 32'(SHOW_0123));
      step(1);
      chk("scr_load", 32'(oHEX), 32'({7'h08, 7'h08, 7'h08, 7'h08}));

      // scroll to offset 2, then drop to static
      iMODE = 2'b00; iDATA = 16'h0123; iLOAD = 1'b1;
      step(1);
      iLOAD = 1'b0; iMODE = 2'b10;
      step(1);
      step(9);
      chk("scr_off2", 32'(oHEX), 32'({7'h24, 7'h30, 7'h40, 7'h79}));
      iMODE = 2'b00;
      step(1);
      chk("sta_rdy", 32'(oREADY), 32'd1);
      step(1);
      chk("sta_unrot", 32'(oHEX), 32'(SHOW_0123));

      // off mode still accepts loads and keeps data
      iMODE = 2'b11; iDATA = 16'h00F5; iLOAD = 1'b1;
      step(1);
      iLOAD = 1'b0;
      step(1);
      chk("off_blank", 32'(oHEX), 32'(ALL_BLANK));
      iMODE = 2'b00; iLZB = 1'b1;
      step(1);
      chk("off_exit", 32'(oHEX), 32'(ALL_BLANK));
      step(1);
      chk("off_keep", 32'(oHEX), 32'({7'h7F, 7'h7F, 7'h0E, 7'h12}));

      // reset pulse mid-scroll
      iMODE = 2'b10;
      step(6);
      chk("mid_rdy", 32'(oREADY), 32'd0);
      iRST = 1'b1; iMODE = 2'b00;
      step(1);
      chk("mid_rst", 32'(oHEX), 32'(ALL_BLANK));
      chk("mid_rrdy", 32'(oREADY), 32'd1);
      iRST = 1'b0;
      step(1);
      chk("post_rst", 32'(oHEX), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule

// File: doc/hex_multi_display.md
HEX_MULTI_DISPLAY -- requirements
Module: hex_multi_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of 7-segment digits driven (legal 1..8).
REQ-002 SHALL have parameter TICK_DIV, default 25_000_000, clock cycles per display tick (legal >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means a segment is lit by driving 0.
REQ-004 SHALL have a single clock and a synchronous active-high reset: iCLK input 1, rising-edge clock; iRST input 1, synchronous active-high reset.
REQ-005 SHALL have iDATA, input, 4*NUM_DIGITS bits, hex value; nibble k feeds digit k (k=0 rightmost).
REQ-006 SHALL have iLOAD, input, 1 bit, load request; accepted on an edge where iLOAD && oREADY.
REQ-007 SHALL have oREADY, output, 1 bit, load may be accepted this cycle.
REQ-008 SHALL have iMODE, input, 2 bits: 00 STATIC, 01 BLINK, 10 SCROLL, 11 OFF.
REQ-009 SHALL have iLZB, input, 1 bit, leading-zero blanking enable (STATIC mode only).
REQ-010 SHALL have oHEX, output, 7*NUM_DIGITS bits, registered segments; bits [7k+6:7k] = digit k, bit 0 = segment a .. bit 6 = segment g.

Function
REQ-011 Data register SHALL capture iDATA on an accepted load; oHEX SHALL reflect the new value on the following edge (load-to-display latency 2 edges).
REQ-012 oREADY SHALL be 1 when mode is not SCROLL, or when scroll offset = 0; otherwise 0.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick = 1 for exactly one cycle when count = TICK_DIV-1.
REQ-014 Blink phase SHALL toggle on every tick; in BLINK, phase 1 blanks all digits and phase 0 shows the data unblanked.
REQ-015 In SCROLL, offset SHALL advance by 1 modulo NUM_DIGITS on every tick; digit i SHALL show nibble (i+offset) mod NUM_DIGITS.
REQ-016 In STATIC with iLZB=1, every digit above the highest non-zero nibble SHALL be blank; digit 0 SHALL never be blanked; all-zero data shows a single "0".
REQ-017 OFF SHALL blank all digits; data register SHALL be retained and loads SHALL still be accepted.
REQ-018 A blank digit SHALL drive all segments unlit (7'h7F when ACTIVE_LOW=1, 7'h00 otherwise).
REQ-019 Registered previous mode SHALL be kept; on any iMODE change, prescaler, offset and blink phase SHALL clear to 0 on that edge, with oHEX showing the new mode on the next edge.
REQ-020 Load and tick on the same edge SHALL both take effect: new data with advanced offset/phase.
REQ-021 Load and mode change on the same edge: oREADY SHALL be evaluated from the pre-edge state; when accepted, the load SHALL take effect and the counters SHALL clear.
REQ-022 Decoding SHALL map 0..F to the standard hex glyphs 0-9, A, b, C, d, E, F.

Reset
REQ-023 While iRST=1 at an edge, the block SHALL clear data register, prescaler, offset, phase and previous mode (to STATIC), and SHALL drive every digit of oHEX blank.
REQ-024 oREADY SHALL be 1 on the first edge after reset.
REQ-025 Reset asserted mid-scroll or mid-blink SHALL abort immediately with no residual state.

Structure
REQ-026 Package hex_disp_pkg SHALL hold the mode enum, the blank-digit constant and the 16-entry glyph table.
REQ-027 Sub-module hex_seg_decode (4-bit to 7-segment, combinational, ACTIVE_LOW parameter) SHALL be instantiated once per digit.

Verification (NUM_DIGITS=4, TICK_DIV=4, ACTIVE_LOW=1)
REQ-028 Reset -> oHEX = {7F,7F,7F,7F}, oREADY=1.
REQ-029 STATIC, load 16'h0012: with iLZB=1, oHEX 2 edges later = digits3..0 {7F,7F,79,24}; with iLZB=0, {40,40,79,24}.
REQ-030 BLINK, load 16'h0123 -> oHEX alternates {40,79,24,30} and {7F,7F,7F,7F}, 4 cycles each.
REQ-031 SCROLL, data 16'h0123, iLOAD held with 16'hAAAA -> after first tick digit0 = 24 ("2") and oREADY=0; load accepted only after offset wraps to 0 (16 cycles after mode entry).
REQ-032 SCROLL at offset 2, switch to STATIC -> counters clear, next edge oHEX = {40,79,24,30} unrotated.
REQ-033 iRST pulsed for 1 cycle mid-scroll -> all blank next edge, then static "0" at digit 0 with iLZB=1.
